// File: rtl/charbuf_pkg.sv
// Shared constants, FSM encoding and address helpers for the character buffer
// port-A arbiter. Address layout is {col[6:0], row[4:0]}.
package charbuf_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 7;
  localparam logic [6:0] MAXCOL = 7'd80;
  localparam logic [5:0] MAXROW = 6'd32;
  localparam logic [DATA_W-1:0] CHAR_NUL = 7'h00;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_INIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic REQ_SCR  = 1'b0;
  localparam logic REQ_TERM = 1'b1;

  function automatic logic [6:0] addrCol(input logic [ADDR_W-1:0] a);
    return a[11:5];
  endfunction

  function automatic logic [4:0] addrRow(input logic [ADDR_W-1:0] a);
    return a[4:0];
  endfunction

  function automatic logic colInRange(input logic [ADDR_W-1:0] a);
    return addrCol(a) < MAXCOL;
  endfunction

endpackage

// File: rtl/charbuf_rd_tag_pipe.sv
// Carries {is_read, requester} alongside the RAM read latency and steers the
// captured read data to the requester that issued the read.
module charbuf_rd_tag_pipe
  import charbuf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tagValid,
  input  logic              tagReq,
  input  logic [DATA_W-1:0] memRdata,
  output logic              scrRvalid,
  output logic              termRvalid,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0] vPipe;
  logic [DEPTH-1:0] rPipe;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vPipe      <= '0;
      rPipe      <= '0;
      scrRvalid  <= 1'b0;
      termRvalid <= 1'b0;
      rdata      <= CHAR_NUL;
    end else begin
      vPipe[0] <= tagValid;
      rPipe[0] <= tagReq;
      for (int i = 1; i < DEPTH; i++) begin
        vPipe[i] <= vPipe[i-1];
        rPipe[i] <= rPipe[i-1];
      end
      scrRvalid  <= vPipe[DEPTH-1] && (rPipe[DEPTH-1] == REQ_SCR);
      termRvalid <= vPipe[DEPTH-1] && (rPipe[DEPTH-1] == REQ_TERM);
      // rdata holds between returns so it only changes on a real read
      if (vPipe[DEPTH-1]) rdata <= memRdata;
    end
  end

endmodule

// File: rtl/charbuf_port_arbiter.sv
// Port-A owner of the character buffer: init engine has absolute priority,
// scroll and terminal share the remaining slots round-robin.
module charbuf_port_arbiter
  import charbuf_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              init_wr_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              scr_valid,
  input  logic              scr_we,
  input  logic [ADDR_W-1:0] scr_addr,
  input  logic [DATA_W-1:0] scr_wdata,
  output logic              scr_ready,
  output logic              scr_rvalid,
  input  logic              term_valid,
  input  logic              term_we,
  input  logic [ADDR_W-1:0] term_addr,
  input  logic [DATA_W-1:0] term_wdata,
  output logic              term_ready,
  output logic              term_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_busy,
  output logic              init_done,
  output logic              err_oob,
  output logic [1:0]        dbgState
);

  // Handshake: a request transfers in the cycle where valid && ready are both
  // high; requesters hold valid/we/addr/wdata stable until then, and ready is
  // never asserted while init_wr_en is high or outside the ARB state.

  state_t            state, stateNext;
  logic              rrLast;
  logic              arbOpen, scrGnt, termGnt, anyGnt;
  logic              selTerm, selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_ARB;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    init_busy = 1'b0;
    init_done = 1'b0;
    case (state)
      ST_ARB: begin
        if (init_wr_en) stateNext = ST_INIT;
      end
      ST_INIT: begin
        init_busy = 1'b1;
        if (!init_wr_en) stateNext = ST_FLUSH;
      end
      ST_FLUSH: begin
        init_done = 1'b1;
        stateNext = init_wr_en ? ST_INIT : ST_ARB;
      end
      default: stateNext = ST_ARB;
    endcase
  end

  assign dbgState = state;

  // With both valid, the requester that did not win last time goes first
  assign arbOpen  = (state == ST_ARB) && !init_wr_en;
  assign scrGnt   = arbOpen && scr_valid && (!term_valid || rrLast == REQ_TERM);
  assign termGnt  = arbOpen && term_valid && (!scr_valid || rrLast == REQ_SCR);
  assign anyGnt   = scrGnt || termGnt;
  assign selTerm  = termGnt;
  assign selWe    = selTerm ? term_we : scr_we;
  assign selAddr  = selTerm ? term_addr : scr_addr;
  assign selWdata = selTerm ? term_wdata : scr_wdata;

  assign scr_ready  = scrGnt;
  assign term_ready = termGnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= CHAR_NUL;
      err_oob   <= 1'b0;
      rrLast    <= REQ_TERM;
    end else if (init_wr_en) begin
      mem_we    <= 1'b1;
      mem_addr  <= init_addr;
      mem_wdata <= init_data;
    end else if (anyGnt) begin
      mem_addr  <= selAddr;
      mem_wdata <= selWdata;
      mem_we    <= selWe && colInRange(selAddr);
      rrLast    <= selTerm;
      // Out-of-range writes are acked but never reach the RAM
      if (selWe && !colInRange(selAddr)) err_oob <= 1'b1;
    end else begin
      mem_we <= 1'b0;
    end
  end

  charbuf_rd_tag_pipe #(
    .DEPTH(1 + RD_LAT)
  ) uTagPipe (
    .clk       (clk),
    .resetn    (resetn),
    .tagValid  (anyGnt && !selWe),
    .tagReq    (selTerm),
    .memRdata  (mem_rdata),
    .scrRvalid (scr_rvalid),
    .termRvalid(term_rvalid),
    .rdata     (rdata)
  );

endmodule

// File: tb/tb_charbuf_port_arbiter.sv
// Bench for charbuf_port_arbiter: RAM model, per-cycle reference checker and
// one task per scenario.
module tb_charbuf_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        init_wr_en = 1'b0;
  logic [11:0] init_addr = '0;
  logic [6:0]  init_data = '0;
  logic        scr_valid = 1'b0, scr_we = 1'b0;
  logic [11:0] scr_addr = '0;
  logic [6:0]  scr_wdata = '0;
  logic        scr_ready, scr_rvalid;
  logic        term_valid = 1'b0, term_we = 1'b0;
  logic [11:0] term_addr = '0;
  logic [6:0]  term_wdata = '0;
  logic        term_ready, term_rvalid;
  logic [6:0]  rdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [6:0]  mem_wdata;
  logic [6:0]  mem_rdata;
  logic        init_busy, init_done, err_oob;
  logic [1:0]  dbgState;

  int checks = 0;
  int errors = 0;

  charbuf_port_arbiter #(.RD_LAT(1)) dut (
    .clk(clk), .resetn(resetn),
    .init_wr_en(init_wr_en), .init_addr(init_addr), .init_data(init_data),
    .scr_valid(scr_valid), .scr_we(scr_we), .scr_addr(scr_addr), .scr_wdata(scr_wdata),
    .scr_ready(scr_ready), .scr_rvalid(scr_rvalid),
    .term_valid(term_valid), .term_we(term_we), .term_addr(term_addr), .term_wdata(term_wdata),
    .term_ready(term_ready), .term_rvalid(term_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_busy(init_busy), .init_done(init_done),
    .err_oob(err_oob), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM with one cycle read latency ----------------
  logic [6:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  logic [6:0]  model_mem [0:4095];
  logic [39:0] exp_q[$];          // {due cycle, requester, data}
  logic        m_live = 1'b0;
  logic        m_p1 = 1'b0, m_p2 = 1'b0;  // init_wr_en one and two cycles ago
  logic        m_rr = 1'b1;               // last winner, 1 = terminal
  logic        m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [11:0] m_addr = '0;
  logic [6:0]  m_wd = '0;

  always @(negedge clk) begin
    logic arb, e_s, e_t, e_sv, e_tv, w;
    logic [11:0] a;
    logic [6:0]  d, e_d;
    logic [39:0] ent;
    if (!resetn) begin
      m_p1 = 0; m_p2 = 0; m_rr = 1; m_err = 0; m_we = 0;
      exp_q.delete();
      m_live = 1;
    end else if (m_live) begin
      arb = !m_p1 && !m_p2 && !init_wr_en;
      e_s = arb && scr_valid && (!term_valid || m_rr);
      e_t = arb && term_valid && (!scr_valid || !m_rr);
      checks++;
      if (scr_ready !== e_s) begin errors++; $display("FAIL mon_scr_ready cyc=%0d got=%b exp=%b", cyc, scr_ready, e_s); end
      checks++;
      if (term_ready !== e_t) begin errors++; $display("FAIL mon_term_ready cyc=%0d got=%b exp=%b", cyc, term_ready, e_t); end
      checks++;
      if (init_busy !== m_p1) begin errors++; $display("FAIL mon_init_busy cyc=%0d got=%b exp=%b", cyc, init_busy, m_p1); end
      checks++;
      if (init_done !== (!m_p1 && m_p2)) begin errors++; $display("FAIL mon_init_done cyc=%0d got=%b exp=%b", cyc, init_done, !m_p1 && m_p2); end
      checks++;
      if (err_oob !== m_err) begin errors++; $display("FAIL mon_err_oob cyc=%0d got=%b exp=%b", cyc, err_oob, m_err); end
      checks++;
      if (mem_we !== m_we) begin errors++; $display("FAIL mon_mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, m_we); end
      if (m_we) begin
        checks++;
        if (mem_addr !== m_addr || mem_wdata !== m_wd) begin
          errors++; $display("FAIL mon_mem_wr cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_addr, mem_wdata, m_addr, m_wd);
        end
      end
      e_sv = 0; e_tv = 0; e_d = '0;
      if (exp_q.size() > 0 && exp_q[0][39:8] == cyc) begin
        ent = exp_q.pop_front();
        e_tv = ent[7]; e_sv = !ent[7]; e_d = ent[6:0];
      end
      checks++;
      if (scr_rvalid !== e_sv || term_rvalid !== e_tv) begin
        errors++; $display("FAIL mon_rvalid cyc=%0d got=%b%b exp=%b%b", cyc, scr_rvalid, term_rvalid, e_sv, e_tv);
      end
      if (e_sv || e_tv) begin
        checks++;
        if (rdata !== e_d) begin errors++; $display("FAIL mon_rdata cyc=%0d got=%h exp=%h", cyc, rdata, e_d); end
      end
      // advance the model to the next cycle
      m_we = 0;
      if (init_wr_en) begin
        m_we = 1; m_addr = init_addr; m_wd = init_data;
        model_mem[init_addr] = init_data;
      end else if (e_s || e_t) begin
        w = e_t ? term_we : scr_we;
        a = e_t ? term_addr : scr_addr;
        d = e_t ? term_wdata : scr_wdata;
        m_rr = e_t;
        if (w) begin
          if (a[11:5] < 7'd80) begin
            m_we = 1; m_addr = a; m_wd = d; model_mem[a] = d;
          end else begin
            m_err = 1;
          end
        end else begin
          exp_q.push_back({cyc + 32'd3, e_t, model_mem[a]});
        end
      end
      m_p2 = m_p1; m_p1 = init_wr_en;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [11:0] rnd_addr();
    logic [6:0] c;
    c = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(76, 90)) : 7'($urandom_range(0, 3));
    return {c, 5'($urandom_range(0, 3))};
  endfunction

  task automatic term_req(input logic we, input logic [11:0] a, input logic [6:0] d);
    int n = 0;
    term_valid = 1; term_we = we; term_addr = a; term_wdata = d;
    @(negedge clk);
    while (!term_ready && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (!term_ready) begin errors++; $display("FAIL term_req_timeout got=0 exp=1"); end
    @(posedge clk); #1;
    term_valid = 0;
  endtask

  task automatic scr_req(input logic we, input logic [11:0] a, input logic [6:0] d);
    int n = 0;
    scr_valid = 1; scr_we = we; scr_addr = a; scr_wdata = d;
    @(negedge clk);
    while (!scr_ready && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (!scr_ready) begin errors++; $display("FAIL scr_req_timeout got=0 exp=1"); end
    @(posedge clk); #1;
    scr_valid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, init_done, err_oob, scr_rvalid, term_rvalid, rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b%h%h%b%b%b%b%h exp=0", mem_we, mem_addr, mem_wdata,
                         init_done, err_oob, scr_rvalid, term_rvalid, rdata);
    end
    checks++;
    if (dbgState !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbgState); end
    resetn = 1;
  endtask

  task automatic test_rr_reads();
    int grants[$];
    int s_left = 4, t_left = 4, s_rv = 0, t_rv = 0;
    logic s_acc, t_acc;
    scr_valid = 1; scr_we = 0; scr_addr = rnd_addr();
    term_valid = 1; term_we = 0; term_addr = rnd_addr();
    for (int n = 0; n < 30 && (s_left > 0 || t_left > 0); n++) begin
      @(negedge clk);
      s_acc = scr_valid && scr_ready;
      t_acc = term_valid && term_ready;
      if (s_acc) grants.push_back(0);
      if (t_acc) grants.push_back(1);
      if (scr_rvalid) s_rv++;
      if (term_rvalid) t_rv++;
      @(posedge clk); #1;
      if (s_acc) begin s_left--; if (s_left == 0) scr_valid = 0; else scr_addr = rnd_addr(); end
      if (t_acc) begin t_left--; if (t_left == 0) term_valid = 0; else term_addr = rnd_addr(); end
    end
    scr_valid = 0; term_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (scr_rvalid) s_rv++;
      if (term_rvalid) t_rv++;
      @(posedge clk); #1;
    end
    checks++;
    if (grants.size() !== 8) begin errors++; $display("FAIL rr_grant_count got=%0d exp=8", grants.size()); end
    for (int i = 0; i < grants.size() && i < 8; i++) begin
      checks++;
      if (grants[i] !== i % 2) begin errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], i % 2); end
    end
    checks++;
    if (s_rv !== 4 || t_rv !== 4) begin errors++; $display("FAIL rr_rvalid_count got=%0d/%0d exp=4/4", s_rv, t_rv); end
  endtask

  task automatic test_init_priority();
    int rdy_bad = 0, we_cnt = 0, done_cnt = 0;
    init_wr_en = 1;
    term_valid = 1; term_we = 0; term_addr = 12'h0A5;
    for (int i = 0; i < 2560; i++) begin
      init_addr = 12'(i); init_data = 7'($urandom);
      @(negedge clk);
      if (term_ready) rdy_bad++;
      if (mem_we) we_cnt++;
      if (init_done) done_cnt++;
      @(posedge clk); #1;
    end
    init_wr_en = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (init_done) done_cnt++;
      if (k == 1) begin
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_flush_done got=%b exp=1", init_done); end
      end
      if (k < 2 && term_ready) rdy_bad++;
      if (k == 2) begin
        checks++;
        if (term_ready !== 1'b1) begin errors++; $display("FAIL init_term_resume got=%b exp=1", term_ready); end
      end
      @(posedge clk); #1;
    end
    term_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rdy_bad !== 0) begin errors++; $display("FAIL init_term_blocked got=%0d exp=0", rdy_bad); end
    checks++;
    if (we_cnt !== 2560) begin errors++; $display("FAIL init_we_pulses got=%0d exp=2560", we_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL init_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_oob();
    term_req(1'b1, {7'd79, 5'd31}, 7'h41);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 12'h9FF || mem_wdata !== 7'h41 || err_oob !== 1'b0) begin
      errors++; $display("FAIL oob_edge_write got=%b/%h/%h/%b exp=1/9ff/41/0", mem_we, mem_addr, mem_wdata, err_oob);
    end
    term_req(1'b1, {7'd80, 5'd0}, 7'h42);
    checks++;
    if (mem_we !== 1'b0 || err_oob !== 1'b1) begin
      errors++; $display("FAIL oob_drop got=%b/%b exp=0/1", mem_we, err_oob);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky got=%b exp=1", err_oob); end
  endtask

  task automatic test_read_then_init();
    logic [6:0] exp_d;
    exp_d = model_mem[12'h123];
    scr_req(1'b0, 12'h123, 7'h00);
    init_wr_en = 1;
    for (int j = 0; j < 6; j++) begin
      init_addr = 12'h300 + 12'(j); init_data = 7'($urandom);
      @(negedge clk);
      if (j >= 1) begin
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL rti_init_gap j=%0d got=%b exp=1", j, mem_we); end
      end
      checks++;
      if (scr_rvalid !== (j == 2)) begin errors++; $display("FAIL rti_rvalid j=%0d got=%b exp=%b", j, scr_rvalid, j == 2); end
      if (j == 2) begin
        checks++;
        if (rdata !== exp_d) begin errors++; $display("FAIL rti_rdata got=%h exp=%h", rdata, exp_d); end
      end
      @(posedge clk); #1;
    end
    init_wr_en = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    term_req(1'b1, 12'h040, 7'h55);
    term_req(1'b0, 12'h040, 7'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (term_rvalid !== 1'b1 || rdata !== 7'h55) begin
      errors++; $display("FAIL wr_rd_same_addr got=%b/%h exp=1/55", term_rvalid, rdata);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int burst = 0;
    logic s_acc, t_acc;
    for (int n = 0; n < 400; n++) begin
      if (burst > 0) begin
        init_wr_en = 1; init_addr = 12'($urandom_range(0, 4095)); init_data = 7'($urandom); burst--;
      end else begin
        init_wr_en = 0;
        if ($urandom_range(0, 40) == 0) burst = $urandom_range(1, 4);
      end
      if (!scr_valid && $urandom_range(0, 2) != 0) begin
        scr_valid = 1; scr_we = 1'($urandom_range(0, 1)); scr_addr = rnd_addr(); scr_wdata = 7'($urandom);
      end
      if (!term_valid && $urandom_range(0, 2) != 0) begin
        term_valid = 1; term_we = 1'($urandom_range(0, 1)); term_addr = rnd_addr(); term_wdata = 7'($urandom);
      end
      @(negedge clk);
      s_acc = scr_valid && scr_ready;
      t_acc = term_valid && term_ready;
      @(posedge clk); #1;
      if (s_acc) scr_valid = 0;
      if (t_acc) term_valid = 0;
    end
    init_wr_en = 0; scr_valid = 0; term_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL random_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    term_req(1'b0, 12'h001, 7'h00);
    term_req(1'b0, 12'h002, 7'h00);
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (scr_rvalid !== 1'b0 || term_rvalid !== 1'b0) begin
        errors++; $display("FAIL rst_inflight_rvalid k=%0d got=%b%b exp=00", k, scr_rvalid, term_rvalid);
      end
      checks++;
      if ({mem_we, mem_addr, mem_wdata, rdata, err_oob, init_done, init_busy, dbgState} !== '0) begin
        errors++; $display("FAIL rst_inflight_outputs k=%0d got=%b/%h/%h/%h/%b/%b/%b/%0d exp=0", k, mem_we, mem_addr,
                           mem_wdata, rdata, err_oob, init_done, init_busy, dbgState);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 7'($urandom);
      model_mem[i] = ram[i];
    end
    test_reset();
    test_rr_reads();
    test_init_priority();
    test_oob();
    test_read_then_init();
    test_write_read();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
